// File: rtl/adbg_crc_pkg.sv
// Shared types, CRC-32 constants and the reflected single-bit CRC step
// used by the Advanced Debug Interface CRC engine.
package adbg_crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } crc_state_e;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  // Reflected (LSB-first) step; caller keeps bits above the CRC width zero.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic        d,
                                           input logic [31:0] poly);
    logic fb;
    fb       = crc[0] ^ d;
    crc_step = (crc >> 1) ^ (fb ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/adbg_crc_engine_if.sv
// Control/data bundle between the JTAG shift logic and the CRC engine.
interface adbg_crc_engine_if #(
  parameter int unsigned CRC_W  = 32,
  parameter int unsigned DATA_W = 1
);
  logic              clr;
  logic [DATA_W-1:0] data_i;
  logic              data_valid;
  logic              shift_start;
  logic              check_start;
  logic              shift_en;
  logic              cmp_bit;
  logic [CRC_W-1:0]  crc_o;
  logic              serial_o;
  logic              busy;
  logic              done;
  logic              crc_ok;

  modport master (
    output clr, data_i, data_valid, shift_start, check_start, shift_en, cmp_bit,
    input  crc_o, serial_o, busy, done, crc_ok
  );

  modport slave (
    input  clr, data_i, data_valid, shift_start, check_start, shift_en, cmp_bit,
    output crc_o, serial_o, busy, done, crc_ok
  );
endinterface

// File: rtl/adbg_crc_fold.sv
// Combinational fold of DATA_W data bits (bit 0 first) into a reflected CRC.
module adbg_crc_fold
  import adbg_crc_pkg::*;
#(
  parameter int unsigned CRC_W  = 32,
  parameter int unsigned DATA_W = 1,
  parameter logic [31:0] POLY   = CRC32_POLY_REFL
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_out
);
  localparam logic [31:0] MASK   = 32'hFFFFFFFF >> (32 - CRC_W);
  localparam logic [31:0] POLY_M = POLY & MASK;

  logic [31:0] c;

  always_comb begin
    c              = '0;
    c[CRC_W-1:0]   = crc_in;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      c = crc_step(c, data[i], POLY_M);
    end
    crc_out = c[CRC_W-1:0];
  end
endmodule

// File: rtl/adbg_crc_engine.sv
// Parametrised reflected CRC generator/checker with counted serial
// shift-out (SHIFT) and serial compare (CHECK) sequences.
module adbg_crc_engine
  import adbg_crc_pkg::*;
#(
  parameter int unsigned CRC_W  = 32,
  parameter int unsigned DATA_W = 1,
  parameter logic [31:0] POLY   = CRC32_POLY_REFL,
  parameter logic [31:0] INIT   = CRC32_INIT
) (
  input logic              clk,
  input logic              rstn,
  adbg_crc_engine_if.slave bus
);
  localparam int unsigned      CW       = $clog2(CRC_W + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(CRC_W - 1);
  localparam logic [CRC_W-1:0] INIT_W   = INIT[CRC_W-1:0];

  crc_state_e       state, state_nxt;
  logic [CRC_W-1:0] crc, crc_nxt, crc_fold;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             mis, mis_nxt;
  logic             ok, ok_nxt;
  logic             done, done_nxt;
  logic             bit_bad;

  adbg_crc_fold #(
    .CRC_W (CRC_W),
    .DATA_W(DATA_W),
    .POLY  (POLY)
  ) u_fold (
    .crc_in (crc),
    .data   (bus.data_i),
    .crc_out(crc_fold)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      crc   <= INIT_W;
      cnt   <= '0;
      mis   <= 1'b0;
      ok    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      crc   <= crc_nxt;
      cnt   <= cnt_nxt;
      mis   <= mis_nxt;
      ok    <= ok_nxt;
      done  <= done_nxt;
    end
  end

  assign bit_bad = bus.cmp_bit ^ crc[0];

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc;
    cnt_nxt   = cnt;
    mis_nxt   = mis;
    ok_nxt    = ok;
    done_nxt  = 1'b0;
    if (bus.clr) begin
      state_nxt = IDLE;
      crc_nxt   = INIT_W;
      cnt_nxt   = '0;
      mis_nxt   = 1'b0;
      ok_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.shift_start) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
          end else if (bus.check_start) begin
            state_nxt = CHECK;
            cnt_nxt   = '0;
            mis_nxt   = 1'b0;
            ok_nxt    = 1'b0;
          end else if (bus.data_valid) begin
            crc_nxt = crc_fold;
          end
        end
        SHIFT, CHECK: begin
          if (bus.shift_en) begin
            crc_nxt = crc >> 1;
            cnt_nxt = cnt + CW'(1);
            if (state == CHECK) mis_nxt = mis | bit_bad;
            // The final compare folds in the current bit, not yet in mis.
            if (cnt == CNT_LAST) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
              if (state == CHECK) ok_nxt = !(mis | bit_bad);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.crc_o    = crc;
  assign bus.serial_o = crc[0];
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.crc_ok   = ok;
endmodule

// File: tb/tb_adbg_crc_engine.sv
// Scoreboard bench for adbg_crc_engine: a DATA_W=1 and a DATA_W=8 instance.
module tb_adbg_crc_engine;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  adbg_crc_engine_if #(.CRC_W(32), .DATA_W(1)) bus1 ();
  adbg_crc_engine_if #(.CRC_W(32), .DATA_W(8)) bus8 ();

  adbg_crc_engine #(.CRC_W(32), .DATA_W(1)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  adbg_crc_engine #(.CRC_W(32), .DATA_W(8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] q_crc[$];
  logic        q_bit[$];
  logic [31:0] m1;
  logic [7:0]  msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  localparam logic [31:0] GOLD = 32'h340BC6D9;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_bit(input logic [31:0] c, input logic d);
    if (c[0] ^ d) return (c >> 1) ^ 32'hEDB88320;
    return c >> 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus1.clr = 0; bus1.data_i = '0; bus1.data_valid = 0; bus1.shift_start = 0;
    bus1.check_start = 0; bus1.shift_en = 0; bus1.cmp_bit = 0;
    bus8.clr = 0; bus8.data_i = '0; bus8.data_valid = 0; bus8.shift_start = 0;
    bus8.check_start = 0; bus8.shift_en = 0; bus8.cmp_bit = 0;
  endtask

  task automatic clr_all();
    bus1.clr = 1; bus8.clr = 1; tick(); bus1.clr = 0; bus8.clr = 0;
    m1 = 32'hFFFFFFFF;
  endtask

  // Feeds "123456789": bit-serially into dut1 (scoreboarded every cycle),
  // a byte every eighth cycle into dut8.
  task automatic feed_msg();
    for (int i = 0; i < 72; i++) begin
      bus1.data_valid = 1; bus1.data_i = msg[i/8][i%8];
      m1 = model_bit(m1, msg[i/8][i%8]);
      q_crc.push_back(m1);
      bus8.data_valid = (i % 8 == 0); bus8.data_i = msg[i/8];
      tick();
      check_eq("fold1", bus1.crc_o, q_crc.pop_front());
    end
    bus1.data_valid = 0; bus8.data_valid = 0;
  endtask

  task automatic check_seq(input int flip, input logic exp_ok);
    bus8.check_start = 1; tick(); bus8.check_start = 0;
    check_eq("chk_busy", 32'(bus8.busy), 32'd1);
    for (int i = 0; i < 32; i++) begin
      bus8.shift_en = 1; bus8.cmp_bit = GOLD[i] ^ (i == flip);
      tick();
    end
    bus8.shift_en = 0;
    check_eq("chk_done", 32'(bus8.done), 32'd1);
    check_eq("chk_ok", 32'(bus8.crc_ok), 32'(exp_ok));
    check_eq("chk_crc0", bus8.crc_o, 32'h0);
  endtask

  initial begin
    logic [31:0] hold;
    logic [7:0]  first8;
    int unsigned dones;
    idle_all();
    rstn = 0; m1 = 32'hFFFFFFFF;
    tick(); tick();
    rstn = 1;
    check_eq("rst_crc", bus1.crc_o, 32'hFFFFFFFF);
    check_eq("rst_flags", {29'd0, bus1.busy, bus1.done, bus1.crc_ok}, 32'd0);
    check_eq("rst_serial", 32'(bus1.serial_o), 32'd1);

    // Single zero bit from INIT.
    bus1.data_valid = 1; bus1.data_i = 1'b0;
    q_crc.push_back(32'h92477CDF);
    tick(); bus1.data_valid = 0;
    check_eq("one_zero", bus1.crc_o, q_crc.pop_front());
    check_eq("one_flags", {29'd0, bus1.busy, bus1.done, bus1.crc_ok}, 32'd0);

    clr_all();
    check_eq("clr_crc", bus1.crc_o, 32'hFFFFFFFF);
    feed_msg();
    check_eq("msg_w1", bus1.crc_o, GOLD);
    check_eq("msg_w8", bus8.crc_o, GOLD);

    // Shift-out, with ignored starts/data mid-sequence.
    for (int i = 0; i < 32; i++) q_bit.push_back(m1[i]);
    bus1.shift_start = 1; tick(); bus1.shift_start = 0;
    check_eq("sh_busy", 32'(bus1.busy), 32'd1);
    check_eq("sh_hold", bus1.crc_o, GOLD);
    dones = 0; first8 = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < 8) first8[i] = bus1.serial_o;
      check_eq("sh_bit", 32'(bus1.serial_o), 32'(q_bit.pop_front()));
      bus1.shift_en = 1;
      bus1.check_start = (i == 5); bus1.data_valid = (i == 5); bus1.data_i = 1'b1;
      tick();
      bus1.check_start = 0; bus1.data_valid = 0;
      if (bus1.done) dones++;
      if (i == 30) check_eq("sh_nodone_early", 32'(bus1.done), 32'd0);
    end
    bus1.shift_en = 0;
    check_eq("sh_first8", 32'(first8), 32'hD9);
    check_eq("sh_done_at", 32'(bus1.done), 32'd1);
    check_eq("sh_crc0", bus1.crc_o, 32'h0);
    check_eq("sh_idle", 32'(bus1.busy), 32'd0);
    tick();
    if (bus1.done) dones++;
    check_eq("sh_done_once", dones, 32'd1);

    // Serial check on dut8, good then bit 5 inverted.
    check_seq(-1, 1'b1);
    clr_all();
    feed_msg();
    check_seq(5, 1'b0);

    // clr mid-SHIFT.
    clr_all();
    feed_msg();
    bus1.shift_start = 1; tick(); bus1.shift_start = 0;
    for (int i = 0; i < 10; i++) begin bus1.shift_en = 1; tick(); end
    bus1.shift_en = 0;
    bus1.clr = 1; tick(); bus1.clr = 0;
    check_eq("clr_mid_crc", bus1.crc_o, 32'hFFFFFFFF);
    check_eq("clr_mid_flags", {30'd0, bus1.busy, bus1.done}, 32'd0);
    tick();
    check_eq("clr_mid_nodone", 32'(bus1.done), 32'd0);

    // rstn mid-CHECK on dut8.
    bus8.check_start = 1; tick(); bus8.check_start = 0;
    for (int i = 0; i < 5; i++) begin bus8.shift_en = 1; bus8.cmp_bit = 1; tick(); end
    bus8.shift_en = 0;
    rstn = 0; tick(); rstn = 1;
    check_eq("rstmid_crc", bus8.crc_o, 32'hFFFFFFFF);
    check_eq("rstmid_flags", {29'd0, bus8.busy, bus8.done, bus8.crc_ok}, 32'd0);

    // shift_start beats data_valid in IDLE.
    m1 = 32'hFFFFFFFF;
    bus1.data_valid = 1; bus1.data_i = 1'b1; m1 = model_bit(m1, 1'b1);
    tick(); bus1.data_valid = 0;
    check_eq("pre_start", bus1.crc_o, m1);
    hold = bus1.crc_o;
    bus1.shift_start = 1; bus1.data_valid = 1; bus1.data_i = 1'b1;
    tick();
    bus1.shift_start = 0; bus1.data_valid = 0;
    check_eq("start_busy", 32'(bus1.busy), 32'd1);
    check_eq("start_drop", bus1.crc_o, m1);
    check_eq("start_same", bus1.crc_o, hold);
    clr_all();
    check_eq("end_idle", 32'(bus1.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adbg_crc_engine.md
Name: adbg_crc_engine

Overview:
Parametrised CRC generator/checker for the Advanced Debug Interface data paths, successor to the 1-bit serial CRC32. It folds DATA_W bits per cycle into a reflected (LSB-first) CRC of configurable width and polynomial. It adds two sequenced modes: a counted serial shift-out of the result, and a serial check mode that compares a received CRC bit-stream against the computed value. It sits between the JTAG shift logic and the bus/CPU sub-modules on both the write (check) and read (generate) paths.

Parameters:
CRC_W, 32, CRC register width (8..32)
DATA_W, 1, bits folded per data_valid cycle (1, 2, 4 or 8)
POLY, 32'hEDB88320, polynomial in reflected form; low CRC_W bits used
INIT, 32'hFFFFFFFF, register value after reset/clr; low CRC_W bits used

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  synchronous active-low reset
clr  input  1  synchronous re-init to INIT; aborts any sequence
data_i  input  DATA_W  data bits; bit 0 folded first
data_valid  input  1  fold data_i this cycle (accepted in IDLE only)
shift_start  input  1  begin CRC_W-bit serial shift-out
check_start  input  1  begin CRC_W-bit serial compare
shift_en  input  1  advance one bit in SHIFT or CHECK
cmp_bit  input  1  received CRC bit, sampled when shift_en in CHECK
crc_o  output  CRC_W  current register
serial_o  output  1  crc_o[0], combinational from register
busy  output  1  high in SHIFT or CHECK
done  output  1  one-cycle pulse after last bit of SHIFT or CHECK
crc_ok  output  1  check result, valid from done until next start/clr

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rstn. No asynchronous logic.
- Reset (rstn=0 at edge): crc=INIT, state=IDLE, bit counter=0, mismatch=0, done=0, crc_ok=0, busy=0.
- Single-bit step: fb=crc[0]^d; crc_next=(crc>>1)^(fb ? POLY : 0). The DATA_W fold applies the step for d=data_i[0], then data_i[1], and so on; the whole fold completes in one cycle.
- Priority each cycle: rstn > clr > state action. clr in any state: crc=INIT, state=IDLE, counter=0, mismatch=0, crc_ok=0, no done pulse.
- IDLE:
  - data_valid: crc=fold(crc,data_i). Latency 1; crc_o updates on the next cycle.
  - Start precedence: shift_start > check_start > data_valid.
  - shift_start: go to SHIFT, counter=0. data_valid in the same cycle is dropped.
  - check_start: go to CHECK, counter=0, mismatch=0, crc_ok=0.
- SHIFT, on shift_en:
  - serial_o (crc[0]) is the bit for this cycle; crc={1'b0,crc[CRC_W-1:1]}; counter++.
  - When counter reaches CRC_W-1 and shift_en is high: go to IDLE, pulse done the next cycle. crc is then 0.
- CHECK, on shift_en:
  - mismatch|=(cmp_bit!=crc[0]); shift as in SHIFT; counter++.
  - On the last bit: go to IDLE, crc_ok=!(mismatch|(cmp_bit!=crc[0])), pulse done.
  - crc is 0 afterwards. Software issues clr before reuse.
- In SHIFT and CHECK, data_valid, shift_start and check_start are ignored; there is no restart mid-sequence. shift_en is ignored in IDLE.
- Bit counter is $clog2(CRC_W+1) bits wide and never wraps; it is cleared on every start.
- serial_o in IDLE shows crc[0], so the first shifted bit is visible before the first shift_en.

Decomposition:
- Package adbg_crc_pkg: state enum {IDLE, SHIFT, CHECK}; constants CRC32_POLY_REFL=32'hEDB88320 and CRC32_INIT=32'hFFFFFFFF; function crc_step(crc, d, poly).
- Sub-module adbg_crc_fold: purely combinational DATA_W-bit fold (parameters CRC_W, DATA_W, POLY). The FSM, counter and flags stay in adbg_crc_engine.

Test Plan:
- Default parameters, reset, then one data_valid with data_i=0 -> crc_o=32'h92477CDF next cycle; busy=0, done=0, crc_ok=0.
- DATA_W=8: feed bytes of ASCII "123456789" (0x31..0x39), one per cycle -> crc_o=32'h340BC6D9 (final-XOR'd value 32'hCBF43926). Repeat with DATA_W=1 over 72 cycles, LSB-first per byte -> same value.
- After "123456789", shift_start then 32 shift_en -> serial_o sequence begins 1,0,0,1,1,0,1,1 (0xD9 LSB-first); done pulses exactly once, one cycle after the 32nd shift_en; crc_o=0.
- After "123456789", check_start, then cmp_bit stream = bits of 32'h340BC6D9 LSB-first -> done pulse with crc_ok=1. Repeat with bit 5 inverted -> crc_ok=0.
- Mid-SHIFT after 10 bits: assert clr -> next cycle crc_o=INIT, busy=0, no done pulse. Separately, assert rstn=0 mid-CHECK -> all outputs at reset values on the next edge.
- In IDLE, assert shift_start and data_valid together -> SHIFT entered and crc_o unchanged. In SHIFT, pulse check_start and data_valid -> both ignored and bit count unaffected.
